next_pc_unit: RTL and testbench

- Program-counter stage downstream of the branch resolution logic. Consumes the 3-bit next-PC opcode resolved in EX, computes the next fetch address, and holds the architectural fetch PC register.
- Drives the instruction-memory address and the IF/ID-ID/EX flush.
- Absorbs fetch back-pressure: a redirect arriving while fetch is blocked is buffered, not lost.

---
 rtl/next_pc_unit.sv | 102 ++++++++++
 tb/tb_next_pc_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// Fetch PC register and next-PC selection. A redirect that arrives while imem stalls is held until accepted.
// Optional redirect counter is enabled by defining NEXT_PC_REDIRECT_CNT_EN.
module next_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [2:0]      next_pc_op,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            if_valid,
  output logic            flush,
  output logic            target_misalign,
  output logic [31:0]     redirect_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pending, pending_next;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] base, sum, target;
  logic            is_jalr, redirect;

  assign is_jalr  = (next_pc_op[1:0] == 2'b11);
  assign redirect = ex_valid & ~next_pc_op[2] & (next_pc_op[1:0] != 2'b00);
  assign base     = is_jalr ? ex_rs1 : ex_pc;
  assign sum      = base + ex_imm;
  assign target   = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;

  assign pc_plus4        = pc + XLEN'(4);
  assign flush           = redirect | (state == PEND);
  assign target_misalign = redirect & target[1];
  assign if_valid        = (state == RUN) & imem_ready & ~flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      pending <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pending <= pending_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect) begin
          if (imem_ready) begin
            pc_next = target;
          end else begin
            pending_next = target;
            state_next   = PEND;
          end
        end else if (!stall && imem_ready) begin
          pc_next = pc_plus4;
        end
      end
      PEND: begin
        // A redirect seen during PEND is younger in program order, so it replaces the buffered one.
        if (imem_ready) begin
          pc_next    = redirect ? target : pending;
          state_next = RUN;
        end else if (redirect) begin
          pending_next = target;
        end
      end
      default: state_next = BOOT;
    endcase
  end

`ifdef NEXT_PC_REDIRECT_CNT_EN
  logic        target_load;
  logic [31:0] cnt;

  assign target_load = imem_ready & (((state == RUN) & redirect) | (state == PEND));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt <= '0;
    else if (target_load) cnt <= cnt + 32'd1;
  end

  assign redirect_cnt = cnt;
`else
  assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed bench for next_pc_unit: reset, redirects, buffered redirects, stall and reserved ops.
// Counter expectations follow NEXT_PC_REDIRECT_CNT_EN when the bench is built with it.
module tb_next_pc_unit;

  logic        clk;
  logic        rstn;
  logic [2:0]  next_pc_op;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic        stall, imem_ready;
  logic [31:0] pc, pc_plus4;
  logic        if_valid, flush, target_misalign;
  logic [31:0] redirect_cnt;

`ifdef NEXT_PC_REDIRECT_CNT_EN
  localparam int CNT_STEP = 1;
`else
  localparam int CNT_STEP = 0;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt  = '0;

  next_pc_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rstn(rstn), .next_pc_op(next_pc_op), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .stall(stall),
    .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4), .if_valid(if_valid),
    .flush(flush), .target_misalign(target_misalign), .redirect_cnt(redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    next_pc_op = 3'b000; ex_valid = 1'b0; ex_pc = '0; ex_imm = '0; ex_rs1 = '0;
    stall = 1'b0; imem_ready = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) tick();
    #1 rstn = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc got %h want %h", pc, 32'h0); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_if_valid got %b want 0", if_valid); end
    n_checks++; if (redirect_cnt !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_cnt got %h want 0", redirect_cnt); end
    exp_cnt = '0;
    tick();
    rstn = 1'b1;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL boot_if_valid got %b want 0", if_valid); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL boot_pc got %h want %h", pc, 32'h0); end
    tick();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL run0_pc got %h want %h", pc, 32'h0); end
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL run0_if_valid got %b want 1", if_valid); end
    tick();
    n_checks++; if (pc !== 32'h4) begin n_fail++; $display("[TB] FAIL seq_pc4 got %h want %h", pc, 32'h4); end
    n_checks++; if (pc_plus4 !== 32'h8) begin n_fail++; $display("[TB] FAIL seq_pc_plus4 got %h want %h", pc_plus4, 32'h8); end
    tick();
    n_checks++; if (pc !== 32'h8) begin n_fail++; $display("[TB] FAIL seq_pc8 got %h want %h", pc, 32'h8); end
    tick();
    n_checks++; if (pc !== 32'hC) begin n_fail++; $display("[TB] FAIL seq_pcC got %h want %h", pc, 32'hC); end
  endtask

  task automatic test_branch();
    ex_valid = 1'b1; next_pc_op = 3'b001; ex_pc = 32'h100; ex_imm = 32'hFFFF_FFF0;
    #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL br_flush got %b want 1", flush); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL br_if_valid got %b want 0", if_valid); end
    n_checks++; if (target_misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL br_misalign got %b want 0", target_misalign); end
    tick();
    ex_valid = 1'b0;
    exp_cnt += CNT_STEP;
    #1;
    n_checks++; if (pc !== 32'hF0) begin n_fail++; $display("[TB] FAIL br_pc got %h want %h", pc, 32'hF0); end
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL br_next_if_valid got %b want 1", if_valid); end
    n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL br_cnt got %h want %h", redirect_cnt, exp_cnt); end
  endtask

  task automatic test_jalr();
    ex_valid = 1'b1; next_pc_op = 3'b011; ex_rs1 = 32'h2003; ex_imm = 32'h4;
    #1;
    n_checks++; if (target_misalign !== 1'b1) begin n_fail++; $display("[TB] FAIL jalr_misalign1 got %b want 1", target_misalign); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL jalr_flush got %b want 1", flush); end
    tick();
    exp_cnt += CNT_STEP;
    ex_rs1 = 32'h2001;
    #1;
    n_checks++; if (pc !== 32'h2006) begin n_fail++; $display("[TB] FAIL jalr_pc1 got %h want %h", pc, 32'h2006); end
    n_checks++; if (target_misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL jalr_misalign0 got %b want 0", target_misalign); end
    tick();
    exp_cnt += CNT_STEP;
    ex_valid = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h2004) begin n_fail++; $display("[TB] FAIL jalr_pc2 got %h want %h", pc, 32'h2004); end
    n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL jalr_cnt got %h want %h", redirect_cnt, exp_cnt); end
  endtask

  task automatic test_pend();
    ex_valid = 1'b1; next_pc_op = 3'b010; ex_pc = 32'h300; ex_imm = 32'h100; imem_ready = 1'b0;
    #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL pend_flush_c1 got %b want 1", flush); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL pend_if_valid_c1 got %b want 0", if_valid); end
    tick();
    ex_valid = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h2004) begin n_fail++; $display("[TB] FAIL pend_pc_c2 got %h want %h", pc, 32'h2004); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL pend_flush_c2 got %b want 1", flush); end
    tick();
    n_checks++; if (pc !== 32'h2004) begin n_fail++; $display("[TB] FAIL pend_pc_c3 got %h want %h", pc, 32'h2004); end
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL pend_flush_c3 got %b want 1", flush); end
    n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL pend_cnt_held got %h want %h", redirect_cnt, exp_cnt); end
    imem_ready = 1'b1;
    #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL pend_flush_rel got %b want 1", flush); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL pend_if_valid_rel got %b want 0", if_valid); end
    tick();
    exp_cnt += CNT_STEP;
    n_checks++; if (pc !== 32'h400) begin n_fail++; $display("[TB] FAIL pend_pc_out got %h want %h", pc, 32'h400); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL pend_flush_out got %b want 0", flush); end
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL pend_if_valid_out got %b want 1", if_valid); end
    n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL pend_cnt got %h want %h", redirect_cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    stall = 1'b1; ex_valid = 1'b1; next_pc_op = 3'b010; ex_pc = 32'h40; ex_imm = 32'h40;
    #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_br_flush got %b want 1", flush); end
    tick();
    exp_cnt += CNT_STEP;
    ex_valid = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h80) begin n_fail++; $display("[TB] FAIL stall_br_pc got %h want %h", pc, 32'h80); end
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_if_valid got %b want 1", if_valid); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_flush got %b want 0", flush); end
    tick();
    n_checks++; if (pc !== 32'h80) begin n_fail++; $display("[TB] FAIL stall_hold_pc got %h want %h", pc, 32'h80); end
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_hold_if_valid got %b want 1", if_valid); end
    stall = 1'b0;
    tick();
    n_checks++; if (pc !== 32'h84) begin n_fail++; $display("[TB] FAIL stall_release_pc got %h want %h", pc, 32'h84); end
  endtask

  task automatic test_no_redirect();
    ex_valid = 1'b0; next_pc_op = 3'b011; ex_rs1 = 32'h1232; ex_imm = 32'h0;
    #1;
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL invalid_flush got %b want 0", flush); end
    n_checks++; if (target_misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL invalid_misalign got %b want 0", target_misalign); end
    tick();
    n_checks++; if (pc !== 32'h88) begin n_fail++; $display("[TB] FAIL invalid_pc got %h want %h", pc, 32'h88); end
    ex_valid = 1'b1; next_pc_op = 3'b101; ex_pc = 32'h40; ex_imm = 32'h2;
    #1;
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL rsvd_flush got %b want 0", flush); end
    n_checks++; if (target_misalign !== 1'b0) begin n_fail++; $display("[TB] FAIL rsvd_misalign got %b want 0", target_misalign); end
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rsvd_if_valid got %b want 1", if_valid); end
    tick();
    ex_valid = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h8C) begin n_fail++; $display("[TB] FAIL rsvd_pc got %h want %h", pc, 32'h8C); end
  endtask

  task automatic test_pend_overwrite();
    ex_valid = 1'b1; next_pc_op = 3'b010; ex_pc = 32'h400; ex_imm = 32'h100; imem_ready = 1'b0;
    tick();
    next_pc_op = 3'b001; ex_pc = 32'h500; ex_imm = 32'h100;
    #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL ovw_flush got %b want 1", flush); end
    tick();
    ex_valid = 1'b0; imem_ready = 1'b1;
    #1;
    n_checks++; if (pc !== 32'h8C) begin n_fail++; $display("[TB] FAIL ovw_pc_held got %h want %h", pc, 32'h8C); end
    tick();
    exp_cnt += CNT_STEP;
    n_checks++; if (pc !== 32'h600) begin n_fail++; $display("[TB] FAIL ovw_pc got %h want %h", pc, 32'h600); end
    n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL ovw_cnt got %h want %h", redirect_cnt, exp_cnt); end
  endtask

  task automatic test_reset_in_pend();
    ex_valid = 1'b1; next_pc_op = 3'b010; ex_pc = 32'h0; ex_imm = 32'h700; imem_ready = 1'b0;
    tick();
    ex_valid = 1'b0;
    #1;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("[TB] FAIL rip_flush_pend got %b want 1", flush); end
    rstn = 1'b0;
    #1;
    exp_cnt = '0;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rip_pc got %h want %h", pc, 32'h0); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("[TB] FAIL rip_flush got %b want 0", flush); end
    n_checks++; if (redirect_cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL rip_cnt got %h want %h", redirect_cnt, exp_cnt); end
    imem_ready = 1'b1;
    tick();
    rstn = 1'b1;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rip_boot_if_valid got %b want 0", if_valid); end
    tick();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rip_run_pc got %h want %h", pc, 32'h0); end
    tick();
    n_checks++; if (pc !== 32'h4) begin n_fail++; $display("[TB] FAIL rip_seq_pc got %h want %h", pc, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jalr();
    test_pend();
    test_stall();
    test_no_redirect();
    test_pend_overwrite();
    test_reset_in_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
